// File: rtl/bus_pkg.sv
// Shared bus constants: arbiter state encoding, master ids and slave-select defaults.
package bus_pkg;

    localparam int unsigned SLAVE_LEN_DEF   = 2;
    localparam int unsigned SLAVE_COUNT_DEF = 3;

    // Master ids double as the bus_sel datapath mux value.
    localparam logic MASTER1 = 1'b0;
    localparam logic MASTER2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } bus_state_e;

endpackage

// File: rtl/select_deserializer.sv
// MSB-first serial slave-id deserializer with bit counter.
// id/done look ahead by including the bit being sampled, so the arbiter
// can act on the full id on the same edge that captures the last bit.
module select_deserializer
    import bus_pkg::*;
#(
    parameter int unsigned SLAVE_LEN = SLAVE_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 valid,
    input  logic                 bit_in,
    output logic [SLAVE_LEN-1:0] id,
    output logic                 done
);

    localparam int unsigned CNT_W = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

    logic [SLAVE_LEN-1:0] r_shift;
    logic [CNT_W-1:0]     r_count;

    assign id   = SLAVE_LEN'({r_shift, bit_in});
    assign done = valid && (r_count == CNT_W'(SLAVE_LEN - 1));

    // Shift register and bit counter; start clears both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (start) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (valid) begin
            r_shift <= id;
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave select and watchdog.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned SLAVE_LEN   = SLAVE_LEN_DEF,
    parameter int unsigned SLAVE_COUNT = SLAVE_COUNT_DEF,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m1_request,
    input  logic                   m2_request,
    input  logic                   m1_slave_select,
    input  logic                   m2_slave_select,
    input  logic                   m1_trans_done,
    input  logic                   m2_trans_done,
    output logic                   m1_grant,
    output logic                   m2_grant,
    output logic                   arbitor_busy,
    output logic                   bus_busy,
    output logic [SLAVE_COUNT-1:0] slave_en,
    output logic                   bus_sel,
    output logic                   timeout,
    output logic                   sel_error
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_SELECT  = SELECT;
    localparam logic [1:0] S_BUSY    = BUSY;
    localparam logic [1:0] S_RELEASE = RELEASE;

    logic [1:0]             r_state,     w_state_nxt;
    logic                   r_last,      w_last_nxt;
    logic [WD_W-1:0]        r_wdog,      w_wdog_nxt;
    logic                   r_grant1,    w_grant1_nxt;
    logic                   r_grant2,    w_grant2_nxt;
    logic                   r_arb_busy,  w_arb_busy_nxt;
    logic                   r_bus_busy,  w_bus_busy_nxt;
    logic [SLAVE_COUNT-1:0] r_slave_en,  w_slave_en_nxt;
    logic                   r_bus_sel,   w_bus_sel_nxt;
    logic                   r_timeout,   w_timeout_nxt;
    logic                   r_sel_error, w_sel_error_nxt;

    logic                 w_des_start;
    logic                 w_des_valid;
    logic [SLAVE_LEN-1:0] w_id;
    logic                 w_id_done;
    logic                 w_req_g;
    logic                 w_bit_g;
    logic                 w_done_g;
    logic                 w_id_ok;

    // Inputs of the currently granted master; bus_sel tracks the owner.
    assign w_req_g  = r_bus_sel ? m2_request      : m1_request;
    assign w_bit_g  = r_bus_sel ? m2_slave_select : m1_slave_select;
    assign w_done_g = r_bus_sel ? m2_trans_done   : m1_trans_done;
    assign w_id_ok  = 32'(w_id) < SLAVE_COUNT;

    select_deserializer #(
        .SLAVE_LEN (SLAVE_LEN)
    ) u_select_deserializer (
        .clk    (clk),
        .reset  (reset),
        .start  (w_des_start),
        .valid  (w_des_valid),
        .bit_in (w_bit_g),
        .id     (w_id),
        .done   (w_id_done)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= MASTER2;
            r_wdog      <= '0;
            r_grant1    <= 1'b0;
            r_grant2    <= 1'b0;
            r_arb_busy  <= 1'b0;
            r_bus_busy  <= 1'b0;
            r_slave_en  <= '0;
            r_bus_sel   <= 1'b0;
            r_timeout   <= 1'b0;
            r_sel_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_wdog      <= w_wdog_nxt;
            r_grant1    <= w_grant1_nxt;
            r_grant2    <= w_grant2_nxt;
            r_arb_busy  <= w_arb_busy_nxt;
            r_bus_busy  <= w_bus_busy_nxt;
            r_slave_en  <= w_slave_en_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_timeout   <= w_timeout_nxt;
            r_sel_error <= w_sel_error_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_wdog_nxt      = r_wdog;
        w_grant1_nxt    = r_grant1;
        w_grant2_nxt    = r_grant2;
        w_bus_busy_nxt  = r_bus_busy;
        w_slave_en_nxt  = r_slave_en;
        w_bus_sel_nxt   = r_bus_sel;
        w_timeout_nxt   = 1'b0;
        w_sel_error_nxt = 1'b0;
        w_des_start     = 1'b0;
        w_des_valid     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (m1_request && (!m2_request || r_last == MASTER2)) begin
                    w_state_nxt   = S_SELECT;
                    w_grant1_nxt  = 1'b1;
                    w_bus_sel_nxt = MASTER1;
                    w_last_nxt    = MASTER1;
                    w_des_start   = 1'b1;
                end else if (m2_request) begin
                    w_state_nxt   = S_SELECT;
                    w_grant2_nxt  = 1'b1;
                    w_bus_sel_nxt = MASTER2;
                    w_last_nxt    = MASTER2;
                    w_des_start   = 1'b1;
                end
            end

            S_SELECT: begin
                if (!w_req_g) begin
                    w_state_nxt  = S_RELEASE;
                    w_grant1_nxt = 1'b0;
                    w_grant2_nxt = 1'b0;
                end else begin
                    w_des_valid = 1'b1;
                    if (w_id_done) begin
                        if (w_id_ok) begin
                            w_state_nxt    = S_BUSY;
                            w_slave_en_nxt = SLAVE_COUNT'(1) << w_id;
                            w_bus_busy_nxt = 1'b1;
                            w_wdog_nxt     = '0;
                        end else begin
                            w_state_nxt     = S_RELEASE;
                            w_sel_error_nxt = 1'b1;
                            w_grant1_nxt    = 1'b0;
                            w_grant2_nxt    = 1'b0;
                        end
                    end
                end
            end

            S_BUSY: begin
                w_wdog_nxt = r_wdog + WD_W'(1);
                if (w_done_g || !w_req_g || r_wdog == WD_W'(TIMEOUT - 1)) begin
                    // Done or withdrawal outranks the watchdog in the same cycle.
                    w_timeout_nxt  = !(w_done_g || !w_req_g);
                    w_state_nxt    = S_RELEASE;
                    w_grant1_nxt   = 1'b0;
                    w_grant2_nxt   = 1'b0;
                    w_slave_en_nxt = '0;
                    w_bus_busy_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_arb_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign m1_grant     = r_grant1;
    assign m2_grant     = r_grant2;
    assign arbitor_busy = r_arb_busy;
    assign bus_busy     = r_bus_busy;
    assign slave_en     = r_slave_en;
    assign bus_sel      = r_bus_sel;
    assign timeout      = r_timeout;
    assign sel_error    = r_sel_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int unsigned TB_SLAVE_LEN   = 2;
    localparam int unsigned TB_SLAVE_COUNT = 3;
    localparam int unsigned TB_TIMEOUT     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request;
    logic       m1_slave_select, m2_slave_select;
    logic       m1_trans_done, m2_trans_done;
    logic       m1_grant, m2_grant;
    logic       arbitor_busy, bus_busy;
    logic [2:0] slave_en;
    logic       bus_sel, timeout, sel_error;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_last;   // model round-robin pointer: 0 = m1 served last, 1 = m2

    bus_arbiter #(
        .SLAVE_LEN   (TB_SLAVE_LEN),
        .SLAVE_COUNT (TB_SLAVE_COUNT),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m1_request      (m1_request),
        .m2_request      (m2_request),
        .m1_slave_select (m1_slave_select),
        .m2_slave_select (m2_slave_select),
        .m1_trans_done   (m1_trans_done),
        .m2_trans_done   (m2_trans_done),
        .m1_grant        (m1_grant),
        .m2_grant        (m2_grant),
        .arbitor_busy    (arbitor_busy),
        .bus_busy        (bus_busy),
        .slave_en        (slave_en),
        .bus_sel         (bus_sel),
        .timeout         (timeout),
        .sel_error       (sel_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

    // Observed outputs packed as {g1,g2,arb_busy,bus_busy,slave_en[2:0],bus_sel,timeout,sel_error}.
    function automatic logic [9:0] outs();
        return {m1_grant, m2_grant, arbitor_busy, bus_busy, slave_en, bus_sel, timeout, sel_error};
    endfunction

    function automatic logic [9:0] ev(bit g1, bit g2, bit ab, bit bb, logic [2:0] se,
                                      bit bs, bit to, bit er);
        return {g1, g2, ab, bb, se, bs, to, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m1_request = 0; m2_request = 0;
        m1_slave_select = 0; m2_slave_select = 0;
        m1_trans_done = 0; m2_trans_done = 0;
    endtask

    // One full transaction. k = BUSY cycle on which the winner ends it
    // (done, or request drop when drop=1); k > TIMEOUT means never.
    task automatic do_txn(input bit r1, input bit r2, input logic [1:0] id, input int k,
                          input bit drop, input bit noise, input string tag);
        bit         w;
        bit         g1, g2, valid;
        logic [2:0] se;
        logic [9:0] e;
        logic [9:0] o;
        w  = (r1 && r2) ? !exp_last : r2;
        g1 = (w == 0);
        g2 = (w == 1);
        valid = (int'(id) < TB_SLAVE_COUNT);
        se = valid ? (3'(1) << id) : 3'b000;

        m1_request = r1; m2_request = r2;
        tick();
        exp_last = w;
        e = ev(g1, g2, 1, 0, 3'b000, w, 0, 0);
        o = outs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s grant: got %b want %b", tag, o, e);
        end

        for (int b = TB_SLAVE_LEN - 1; b >= 0; b--) begin
            if (w == 0) m1_slave_select = id[b]; else m2_slave_select = id[b];
            if (noise) begin
                if (w == 0) begin
                    m2_slave_select = 1'($urandom_range(0, 1));
                    m2_trans_done   = 1'($urandom_range(0, 1));
                    m1_trans_done   = 1'($urandom_range(0, 1));
                end else begin
                    m1_slave_select = 1'($urandom_range(0, 1));
                    m1_trans_done   = 1'($urandom_range(0, 1));
                    m2_trans_done   = 1'($urandom_range(0, 1));
                end
            end
            tick();
            if (b > 0)      e = ev(g1, g2, 1, 0, 3'b000, w, 0, 0);
            else if (valid) e = ev(g1, g2, 1, 1, se, w, 0, 0);
            else            e = ev(0, 0, 1, 0, 3'b000, w, 0, 1);
            o = outs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s select_bit%0d: got %b want %b", tag, b, o, e);
            end
        end
        m1_trans_done = 0; m2_trans_done = 0;

        if (valid) begin
            for (int c = 1; c <= int'(TB_TIMEOUT); c++) begin
                if (w == 0) m1_trans_done = 0; else m2_trans_done = 0;
                if (c == k) begin
                    if (drop) begin
                        if (w == 0) m1_request = 0; else m2_request = 0;
                    end else begin
                        if (w == 0) m1_trans_done = 1; else m2_trans_done = 1;
                    end
                end
                if (noise) begin
                    if (w == 0) begin
                        m2_slave_select = 1'($urandom_range(0, 1));
                        m2_trans_done   = 1'($urandom_range(0, 1));
                    end else begin
                        m1_slave_select = 1'($urandom_range(0, 1));
                        m1_trans_done   = 1'($urandom_range(0, 1));
                    end
                end
                tick();
                if (c == k)                    e = ev(0, 0, 1, 0, 3'b000, w, 0, 0);
                else if (c == int'(TB_TIMEOUT)) e = ev(0, 0, 1, 0, 3'b000, w, 1, 0);
                else                           e = ev(g1, g2, 1, 1, se, w, 0, 0);
                o = outs();
                n_cmp++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL %s busy_cyc%0d: got %b want %b", tag, c, o, e);
                end
                if (c == k) break;
            end
        end

        // RELEASE observed; the loser keeps its request, winner lets go.
        m1_trans_done = 0; m2_trans_done = 0;
        m1_slave_select = 0; m2_slave_select = 0;
        if (w == 0) m1_request = 0; else m2_request = 0;
        tick();
        e = ev(0, 0, 0, 0, 3'b000, w, 0, 0);
        o = outs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s idle_after_release: got %b want %b", tag, o, e);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        n_cmp++;
        if (outs() !== 10'b0) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", outs(), 10'b0);
        end
        reset = 0;
        exp_last = 1;
        tick();
        n_cmp++;
        if (outs() !== 10'b0) begin
            n_err++;
            $display("FAIL reset_released: got %b want %b", outs(), 10'b0);
        end
    endtask

    task automatic test_single();
        do_txn(1, 0, 2'b10, 3, 0, 0, "single_m1");
    endtask

    task automatic test_contention();
        do_txn(1, 1, 2'b00, 2, 0, 0, "contend_first");
        do_txn(0, 1, 2'b01, 1, 0, 0, "contend_second");
        do_txn(1, 1, 2'b10, 4, 0, 0, "contend_rr");
        m2_request = 0;
        tick();
    endtask

    task automatic test_invalid_id();
        do_txn(0, 1, 2'b11, 1, 0, 0, "invalid_id");
    endtask

    task automatic test_watchdog();
        do_txn(1, 0, 2'b01, TB_TIMEOUT + 1, 0, 0, "watchdog_fire");
        do_txn(0, 1, 2'b00, TB_TIMEOUT, 0, 0, "watchdog_done_wins");
    endtask

    task automatic test_interference();
        do_txn(1, 0, 2'b10, 6, 0, 1, "noise_done");
        do_txn(1, 0, 2'b00, 3, 1, 1, "noise_drop");
    endtask

    task automatic test_select_drop();
        m2_request = 1;
        tick();
        exp_last = 1;
        n_cmp++;
        if (outs() !== ev(0, 1, 1, 0, 3'b000, 1, 0, 0)) begin
            n_err++;
            $display("FAIL seldrop_grant: got %b want %b", outs(), ev(0, 1, 1, 0, 3'b000, 1, 0, 0));
        end
        m2_request = 0;
        m2_slave_select = 1;
        tick();
        n_cmp++;
        if (outs() !== ev(0, 0, 1, 0, 3'b000, 1, 0, 0)) begin
            n_err++;
            $display("FAIL seldrop_release: got %b want %b", outs(), ev(0, 0, 1, 0, 3'b000, 1, 0, 0));
        end
        m2_slave_select = 0;
        tick();
        n_cmp++;
        if (outs() !== ev(0, 0, 0, 0, 3'b000, 1, 0, 0)) begin
            n_err++;
            $display("FAIL seldrop_idle: got %b want %b", outs(), ev(0, 0, 0, 0, 3'b000, 1, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        // mid-SELECT
        m2_request = 1;
        tick();
        m2_slave_select = 1;
        tick();
        reset = 1;
        #1;
        n_cmp++;
        if (outs() !== 10'b0) begin
            n_err++;
            $display("FAIL reset_mid_select: got %b want %b", outs(), 10'b0);
        end
        clear_inputs();
        tick();
        reset = 0;
        exp_last = 1;
        m1_request = 1; m2_request = 1;
        tick();
        exp_last = 0;
        n_cmp++;
        if (outs() !== ev(1, 0, 1, 0, 3'b000, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_select_regrant: got %b want %b", outs(), ev(1, 0, 1, 0, 3'b000, 0, 0, 0));
        end
        m1_request = 0; m2_request = 0;
        tick();
        tick();
        // mid-BUSY
        m2_request = 1;
        tick();
        m2_slave_select = 0;
        tick();
        tick();
        exp_last = 1;
        n_cmp++;
        if (outs() !== ev(0, 1, 1, 1, 3'b001, 1, 0, 0)) begin
            n_err++;
            $display("FAIL reset_busy_setup: got %b want %b", outs(), ev(0, 1, 1, 1, 3'b001, 1, 0, 0));
        end
        reset = 1;
        #1;
        n_cmp++;
        if (outs() !== 10'b0) begin
            n_err++;
            $display("FAIL reset_mid_busy: got %b want %b", outs(), 10'b0);
        end
        clear_inputs();
        tick();
        reset = 0;
        exp_last = 1;
        m1_request = 1; m2_request = 1;
        tick();
        exp_last = 0;
        n_cmp++;
        if (outs() !== ev(1, 0, 1, 0, 3'b000, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_busy_regrant: got %b want %b", outs(), ev(1, 0, 1, 0, 3'b000, 0, 0, 0));
        end
        m1_request = 0; m2_request = 0;
        tick();
        tick();
        n_cmp++;
        if (outs() !== 10'b0) begin
            n_err++;
            $display("FAIL reset_busy_idle: got %b want %b", outs(), 10'b0);
        end
    endtask

    task automatic test_random();
        int         pat;
        logic [1:0] id;
        for (int i = 0; i < 40; i++) begin
            pat = int'($urandom_range(1, 3));
            id  = 2'($urandom_range(0, 3));
            do_txn(pat[0], pat[1], id, int'($urandom_range(1, TB_TIMEOUT + 2)),
                   1'($urandom_range(0, 1)), 1, $sformatf("rand%0d", i));
        end
        m1_request = 0; m2_request = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_invalid_id();
        test_watchdog();
        test_interference();
        test_select_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
